lane_spawn_ctrl: RTL and testbench



---
 rtl/lane_spawn_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lane_spawn_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_spawn_ctrl.sv
// Spawn controller for the x-coordinate register bank: round-robin free-slot pick, bounded LFSR lane, one-hot load strobe.
// Optional build macro LANE_NO_REPEAT_EN: reject a lane equal to the previous spawn's lane.
module lane_spawn_ctrl #(
  parameter int         NUM_SLOTS  = 10,
  parameter int         GAP_CYCLES = 50,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         MAX_LANE   = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 spawn_req,
  input  logic [NUM_SLOTS-1:0] slot_free,
  output logic [NUM_SLOTS-1:0] load_x,
  output logic [3:0]           rand_int,
  output logic                 spawn_ack,
  output logic                 busy
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [GW-1:0]        GAP_LOAD  = GW'(GAP_CYCLES - 2);
  localparam logic [GW-1:0]        GAP_ONE   = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [3:0]           LANE_MAX  = 4'(MAX_LANE);
  localparam logic [NUM_SLOTS-1:0] SLOT_ONE  = {{(NUM_SLOTS-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]        SLOT_LAST = SW'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    LOAD = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [7:0]             lfsr_r;
  logic [SW-1:0]          ptr_r, ptr_s;
  logic [SW-1:0]          slot_r, slot_s;
  logic [GW-1:0]          gap_r, gap_s;
  logic [SW:0]            pick_s;
  logic                   pick_found_s;
  logic [SW-1:0]          pick_idx_s;
  logic [3:0]             cand_s;
  logic                   lane_ok_s;
  logic [3:0]             rand_s;
  logic [NUM_SLOTS-1:0]   load_s;
  logic                   ack_s;
`ifdef LANE_NO_REPEAT_EN
  logic                   has_spawned_r;
`endif

  // x^8+x^6+x^5+x^4+1, shifting left; feedback taps are stages 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == SLOT_LAST) ? {SW{1'b0}} : s + {{(SW-1){1'b0}}, 1'b1};
  endfunction

  // Returns {found, index}; scanning downward lets the entry nearest the start win.
  function automatic logic [SW:0] rr_pick(input logic [NUM_SLOTS-1:0] free,
                                          input logic [SW-1:0] start);
    logic [SW:0]   res;
    logic [SW-1:0] pos;
    int            idx;
    res = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NUM_SLOTS) begin
        idx = idx - NUM_SLOTS;
      end
      pos = SW'(idx);
      if (free[pos]) begin
        res = {1'b1, pos};
      end
    end
    return res;
  endfunction

  // Free-running lane source, independent of FSM state and enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Round-robin slot search and lane acceptance.
  always_comb begin
    pick_s       = rr_pick(slot_free, ptr_r);
    pick_found_s = pick_s[SW];
    pick_idx_s   = pick_s[SW-1:0];
    cand_s       = lfsr_r[3:0];
`ifdef LANE_NO_REPEAT_EN
    lane_ok_s    = (cand_s <= LANE_MAX) && !(has_spawned_r && (cand_s == rand_int));
`else
    lane_ok_s    = (cand_s <= LANE_MAX);
`endif
  end

  // Next-state and next-output logic. The gap counter is loaded on entry to LOAD
  // and counts through LOAD and GAP, so back-to-back strobes land GAP_CYCLES apart.
  always_comb begin
    state_s = state_r;
    slot_s  = slot_r;
    ptr_s   = ptr_r;
    gap_s   = gap_r;
    rand_s  = rand_int;
    load_s  = '0;
    ack_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && spawn_req && pick_found_s) begin
          slot_s  = pick_idx_s;
          state_s = PICK;
        end else begin
          state_s = IDLE;
        end
      end
      PICK: begin
        if (enable && lane_ok_s) begin
          rand_s  = cand_s;
          load_s  = SLOT_ONE << slot_r;
          ack_s   = 1'b1;
          gap_s   = GAP_LOAD;
          state_s = LOAD;
        end else begin
          state_s = PICK;
        end
      end
      LOAD: begin
        ptr_s   = slot_inc(slot_r);
        gap_s   = gap_r - GAP_ONE;
        state_s = GAP;
      end
      GAP: begin
        if (!enable) begin
          state_s = GAP;
        end else if (gap_r <= GAP_ONE) begin
          gap_s   = '0;
          state_s = IDLE;
        end else begin
          gap_s   = gap_r - GAP_ONE;
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; busy follows the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      slot_r    <= '0;
      ptr_r     <= '0;
      gap_r     <= '0;
      load_x    <= '0;
      rand_int  <= 4'd0;
      spawn_ack <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      slot_r    <= slot_s;
      ptr_r     <= ptr_s;
      gap_r     <= gap_s;
      load_x    <= load_s;
      rand_int  <= rand_s;
      spawn_ack <= ack_s;
      busy      <= (state_s != IDLE);
    end
  end

`ifdef LANE_NO_REPEAT_EN
  // Marks that rand_int now holds a real previous lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      has_spawned_r <= 1'b0;
    end else begin
      has_spawned_r <= has_spawned_r | ack_s;
    end
  end
`endif

endmodule

// File: tb/tb_lane_spawn_ctrl.sv
// Self-checking bench for lane_spawn_ctrl: directed sequence against a cycle-indexed LFSR reference.
`timescale 1ns/1ps
module tb_lane_spawn_ctrl;

  localparam int NS    = 10;
  localparam int HSIZE = 16384;

  logic          clk = 1'b0;
  logic          reset, enable, spawn_req, spawn_req2;
  logic [NS-1:0] slot_free, slot_free2, load_x, load_x2;
  logic [3:0]    rand_int, rand_int2;
  logic          spawn_ack, spawn_ack2, busy, busy2;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  logic [7:0]    m1, m2;
  logic [7:0]    hist1 [0:HSIZE-1];
  logic [7:0]    hist2 [0:HSIZE-1];
  bit            tb_has;
  logic [3:0]    tb_prev;
  int            last_s, start2, n, j;
  logic [3:0]    prev_dut;
  logic [NS-1:0] es;

  always #5 clk = ~clk;

  lane_spawn_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .spawn_req(spawn_req),
    .slot_free(slot_free), .load_x(load_x), .rand_int(rand_int),
    .spawn_ack(spawn_ack), .busy(busy)
  );

  lane_spawn_ctrl #(.LFSR_SEED(8'h0F)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .spawn_req(spawn_req2),
    .slot_free(slot_free2), .load_x(load_x2), .rand_int(rand_int2),
    .spawn_ack(spawn_ack2), .busy(busy2)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR values: advance every clock, seeded on reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1 <= 8'hA5;
      m2 <= 8'h0F;
    end else begin
      m1 <= lfsr_step(m1);
      m2 <= lfsr_step(m2);
    end
  end

  function automatic bit lane_ok(input logic [3:0] v);
    bit ok;
    ok = (v <= 4'd14);
`ifdef LANE_NO_REPEAT_EN
    if (tb_has && (v == tb_prev)) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    hist1[cyc % HSIZE] = m1;
    hist2[cyc % HSIZE] = m2;
  endtask

  // start = first cycle the FSM is in PICK; the strobe follows the first acceptable nibble.
  task automatic expect_spawn(input int start, input logic [NS-1:0] exp_slot, input string tag);
    int k, q, s_exp;
    logic [3:0] lane;
    k = 0;
    while (load_x === 10'h000 && k < 400) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < 400), 32'd1);
    q = 0;
    while (q < 300 && !lane_ok(hist1[(start + q) % HSIZE][3:0])) q++;
    s_exp = start + 1 + q;
    lane  = hist1[(cyc - 1) % HSIZE][3:0];
    chk({tag, "_time"}, cyc, s_exp);
    chk({tag, "_slot"}, load_x, exp_slot);
    chk({tag, "_ack"}, spawn_ack, 32'd1);
    chk({tag, "_busy"}, busy, 32'd1);
    chk({tag, "_lane"}, rand_int, lane);
    chk({tag, "_range"}, 32'(rand_int <= 4'd14), 32'd1);
    tb_prev = lane;
    tb_has  = 1'b1;
    last_s  = cyc;
    tick();
    chk({tag, "_pulse_load"}, load_x, 32'd0);
    chk({tag, "_pulse_ack"}, spawn_ack, 32'd0);
    chk({tag, "_hold"}, rand_int, tb_prev);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; spawn_req = 1'b0; spawn_req2 = 1'b0;
    slot_free = 10'h3FF; slot_free2 = 10'h3FF;
    tb_has = 1'b0; tb_prev = 4'd0; last_s = 0;
    tick(); tick();
    chk("rst_load_x", load_x, 32'd0);
    chk("rst_ack", spawn_ack, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_rand", rand_int, 32'd0);

    // Continuous request, all slots free: slots 0,1,2 spaced by the gap.
    spawn_req = 1'b1;
    reset = 1'b0;
    expect_spawn(cyc + 1, 10'h001, "s0");
    expect_spawn(last_s + 49, 10'h002, "s1");
    expect_spawn(last_s + 49, 10'h004, "s2");

    // Reset during GAP.
    repeat (5) tick();
    chk("gap_busy", busy, 32'd1);
    reset = 1'b1;
    #1;
    chk("gaprst_load_x", load_x, 32'd0);
    chk("gaprst_ack", spawn_ack, 32'd0);
    chk("gaprst_busy", busy, 32'd0);
    chk("gaprst_rand", rand_int, 32'd0);
    tb_has = 1'b0;
    tick();
    reset = 1'b0;
    expect_spawn(cyc + 1, 10'h001, "ptr_reset");
    spawn_req = 1'b0;
    repeat (60) tick();
    chk("idle_after_gap", busy, 32'd0);

    // No free slots: nothing happens until one appears.
    slot_free = 10'h000;
    spawn_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("nofree_load", load_x, 32'd0);
      chk("nofree_busy", busy, 32'd0);
    end
    slot_free = 10'h200;
    expect_spawn(cyc + 1, 10'h200, "late_free");

    // Pointer to 9, then wrap 9 -> 0.
    slot_free = 10'h100;
    expect_spawn(last_s + 49, 10'h100, "to_slot8");
    slot_free = 10'h201;
    expect_spawn(last_s + 49, 10'h200, "wrap_a");
    expect_spawn(last_s + 49, 10'h001, "wrap_b");

    // Enable low during GAP freezes the counter for 10 cycles.
    slot_free = 10'h3FF;
    enable = 1'b0;
    repeat (10) tick();
    chk("frozen_busy", busy, 32'd1);
    enable = 1'b1;
    expect_spawn(last_s + 59, 10'h002, "freeze");

    // Reset during PICK.
    spawn_req = 1'b0;
    repeat (60) tick();
    chk("idle_again", busy, 32'd0);
    spawn_req = 1'b1;
    tick();
    chk("pick_busy", busy, 32'd1);
    chk("pick_load_x", load_x, 32'd0);
    reset = 1'b1;
    #1;
    chk("pickrst_load_x", load_x, 32'd0);
    chk("pickrst_ack", spawn_ack, 32'd0);
    chk("pickrst_busy", busy, 32'd0);
    chk("pickrst_rand", rand_int, 32'd0);
    tb_has = 1'b0;
    spawn_req = 1'b0;
    tick();
    reset = 1'b0;

    // Seed 8'h0F: first PICK candidate is 15, so at least one retry.
    spawn_req2 = 1'b1;
    start2 = cyc + 1;
    n = 0;
    while (load_x2 === 10'h000 && n < 400) begin
      tick();
      n++;
    end
    chk("seed_timeout", 32'(n < 400), 32'd1);
    j = 0;
    while (j < 300 && hist2[(start2 + j) % HSIZE][3:0] > 4'd14) j++;
    chk("seed_time", cyc, start2 + 1 + j);
    chk("seed_retry", 32'((cyc - start2) >= 2), 32'd1);
    chk("seed_slot", load_x2, 10'h001);
    chk("seed_ack", spawn_ack2, 32'd1);
    chk("seed_lane", rand_int2, hist2[(cyc - 1) % HSIZE][3:0]);
    chk("seed_range", 32'(rand_int2 <= 4'd14), 32'd1);
    spawn_req2 = 1'b0;

    // Enable low holds IDLE despite a pending request.
    enable = 1'b0;
    spawn_req = 1'b1;
    repeat (5) tick();
    chk("idle_disabled", busy, 32'd0);
    enable = 1'b1;

    // 100 back-to-back spawns rotating through all slots.
    prev_dut = 4'd0;
    for (int k = 0; k < 100; k++) begin
      es = 10'h001 << (k % 10);
      expect_spawn((k == 0) ? cyc + 1 : last_s + 49, es, "bb");
`ifdef LANE_NO_REPEAT_EN
      if (k > 0) chk("bb_norepeat", 32'(rand_int !== prev_dut), 32'd1);
`endif
      prev_dut = rand_int;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
